wave_scheduler: RTL and testbench

Sequences the fire grid's update rhythm for `game_controller`. It replaces the free-running divided clock with single-cycle, `clk`-domain update strobes. Every update is preceded by a warning window that drives grid blinking, and the interval between updates shrinks as the score rises. It sits between the top-level clock/reset and `game_controller`, which consumes `fire_update` as its pattern-advance enable.

---
 rtl/game_pkg.sv | 37 +++
 rtl/tick_prescaler.sv | 38 +++
 rtl/wave_scheduler.sv | 141 ++++++++++++++
 tb/tb_wave_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings and helpers for the fire-grid game: scheduler phases,
// controller game states and the score-dependent update interval.
package game_pkg;

    localparam int SCORE_W = 4;

    typedef enum logic [1:0] {
        PHASE_IDLE   = 2'b00,
        PHASE_ACTIVE = 2'b01,
        PHASE_WARN   = 2'b10
    } phase_e;

    typedef enum logic [1:0] {
        GAME_ATTRACT = 2'b00,
        GAME_PLAY    = 2'b01,
        GAME_OVER    = 2'b10
    } game_state_e;

    // Interval shrinks with score; the signed intermediate lets the clamp
    // catch values that would otherwise wrap below zero.
    function automatic logic [SCORE_W-1:0] computePeriod(
        input logic [SCORE_W-1:0] score,
        input int                 baseTicks,
        input int                 minTicks,
        input int                 stepTicks
    );
        logic [7:0]        prod;
        logic signed [7:0] raw;
        prod = 8'(score) * 8'(stepTicks);
        raw  = $signed(8'(baseTicks) - prod);
        if (raw < $signed(8'(minTicks))) begin
            return SCORE_W'(minTicks);
        end
        return raw[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to single-cycle scheduler ticks; frozen while disabled
// and restarted from zero whenever the scheduler changes state.
module tick_prescaler #(
    parameter int CLK_PER_TICK = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_TICK - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/wave_scheduler.sv
// Produces the fire grid's update strobes: a score-dependent ACTIVE interval
// followed by a blinking WARN window that ends in a single fire_update pulse.
module wave_scheduler
    import game_pkg::*;
#(
    parameter int CLK_PER_TICK = 1_000_000,
    parameter int BASE_TICKS   = 8,
    parameter int MIN_TICKS    = 3,
    parameter int STEP_TICKS   = 1,
    parameter int WARN_TICKS   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               hold,
    input  logic [SCORE_W-1:0] score,
    output logic [1:0]         phase,
    output logic               warn_start,
    output logic               fire_update,
    output logic               warning,
    output logic               blink,
    output logic [SCORE_W-1:0] period
);

    localparam logic [SCORE_W-1:0] WARN_LOAD = SCORE_W'(WARN_TICKS);
    localparam logic [SCORE_W-1:0] CNT_LAST  = SCORE_W'(1);

    phase_e             state_q, state_d;
    logic [SCORE_W-1:0] tickCnt_q, tickCnt_d;
    logic [SCORE_W-1:0] period_q, period_d;
    logic               warnStart_q, warnStart_d;
    logic               fireUpdate_q, fireUpdate_d;
    logic               warning_q, warning_d;
    logic               blink_q, blink_d;

    logic               tick;
    logic               prescEn;
    logic               prescClr;
    logic [SCORE_W-1:0] newPeriod;

    assign newPeriod = computePeriod(score, BASE_TICKS, MIN_TICKS, STEP_TICKS);
    assign prescEn   = (state_q != PHASE_IDLE) && !hold;
    assign prescClr  = (state_d != state_q);

    tick_prescaler #(
        .CLK_PER_TICK(CLK_PER_TICK)
    ) uPrescaler (
        .clk (clk),
        .rst (rst),
        .en  (prescEn),
        .clr (prescClr),
        .tick(tick)
    );

    // Dropping run overrides everything; hold freezes the whole schedule,
    // so an expiry coinciding with hold simply waits for the next live tick.
    always_comb begin
        state_d      = state_q;
        tickCnt_d    = tickCnt_q;
        period_d     = period_q;
        warning_d    = warning_q;
        blink_d      = blink_q;
        warnStart_d  = 1'b0;
        fireUpdate_d = 1'b0;

        if (!run) begin
            state_d   = PHASE_IDLE;
            warning_d = 1'b0;
            blink_d   = 1'b0;
        end else if (!hold) begin
            case (state_q)
                PHASE_IDLE: begin
                    state_d   = PHASE_ACTIVE;
                    period_d  = newPeriod;
                    tickCnt_d = newPeriod - WARN_LOAD;
                end
                PHASE_ACTIVE: begin
                    if (tick) begin
                        if (tickCnt_q == CNT_LAST) begin
                            state_d     = PHASE_WARN;
                            warnStart_d = 1'b1;
                            warning_d   = 1'b1;
                            tickCnt_d   = WARN_LOAD;
                            blink_d     = 1'b0;
                        end else begin
                            tickCnt_d = tickCnt_q - 1'b1;
                        end
                    end
                end
                PHASE_WARN: begin
                    if (tick) begin
                        blink_d = ~blink_q;
                        if (tickCnt_q == CNT_LAST) begin
                            state_d      = PHASE_ACTIVE;
                            fireUpdate_d = 1'b1;
                            warning_d    = 1'b0;
                            blink_d      = 1'b0;
                            period_d     = newPeriod;
                            tickCnt_d    = newPeriod - WARN_LOAD;
                        end else begin
                            tickCnt_d = tickCnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d   = PHASE_IDLE;
                    warning_d = 1'b0;
                    blink_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PHASE_IDLE;
            tickCnt_q    <= '0;
            period_q     <= SCORE_W'(BASE_TICKS);
            warnStart_q  <= 1'b0;
            fireUpdate_q <= 1'b0;
            warning_q    <= 1'b0;
            blink_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tickCnt_q    <= tickCnt_d;
            period_q     <= period_d;
            warnStart_q  <= warnStart_d;
            fireUpdate_q <= fireUpdate_d;
            warning_q    <= warning_d;
            blink_q      <= blink_d;
        end
    end

    assign phase       = state_q;
    assign warn_start  = warnStart_q;
    assign fire_update = fireUpdate_q;
    assign warning     = warning_q;
    assign blink       = blink_q;
    assign period      = period_q;

endmodule

// File: tb/tb_wave_scheduler.sv
// Scoreboard bench for wave_scheduler: expected warn/fire/blink events are
// queued with their cycle stamps and matched as the DUT emits them.
module tb_wave_scheduler;

    localparam int CPT  = 4;
    localparam int BASE = 8;
    localparam int MINT = 3;
    localparam int STEP = 1;
    localparam int WARN = 2;

    localparam int EV_WARN  = 1;
    localparam int EV_FIRE  = 2;
    localparam int EV_BLINK = 3;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } event_t;

    logic       clk;
    logic       rst;
    logic       run;
    logic       hold;
    logic [3:0] score;
    logic [1:0] phase;
    logic       warn_start;
    logic       fire_update;
    logic       warning;
    logic       blink;
    logic [3:0] period;

    int     edgeCount = 0;
    int     testsRun = 0;
    int     testsFailed = 0;
    logic   prevBlink = 1'b0;
    event_t expQ[$];

    wave_scheduler #(
        .CLK_PER_TICK(CPT),
        .BASE_TICKS  (BASE),
        .MIN_TICKS   (MINT),
        .STEP_TICKS  (STEP),
        .WARN_TICKS  (WARN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .hold       (hold),
        .score      (score),
        .phase      (phase),
        .warn_start (warn_start),
        .fire_update(fire_update),
        .warning    (warning),
        .blink      (blink),
        .period     (period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCount++;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, observed, expected, edgeCount);
        end
    endtask

    task automatic applyStimulus(input logic runV, input logic holdV, input logic [3:0] scoreV);
        run   = runV;
        hold  = holdV;
        score = scoreV;
    endtask

    task automatic waitUntil(input int cyc);
        while (edgeCount < cyc) @(negedge clk);
    endtask

    function automatic int expPeriod(input int s);
        int v;
        v = BASE - s * STEP;
        return (v < MINT) ? MINT : v;
    endfunction

    task automatic pushEvent(input int cyc, input int kind, input int val);
        event_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        expQ.push_back(e);
    endtask

    // One interval starting at the cycle the previous interval began
    // (run sample or previous fire); withFire=0 models run dropping at expiry.
    task automatic pushInterval(input int start, input int p, input bit withFire, output int fireCyc);
        int warnCyc;
        int bl;
        fireCyc = start + p * CPT;
        warnCyc = fireCyc - WARN * CPT;
        bl = 0;
        pushEvent(warnCyc, EV_WARN, 1);
        for (int j = 1; j <= WARN; j++) begin
            if (j < WARN) begin
                bl = bl ^ 1;
                pushEvent(warnCyc + j * CPT, EV_BLINK, bl);
            end else begin
                if (withFire) pushEvent(warnCyc + j * CPT, EV_FIRE, 1);
                if (bl != 0) pushEvent(warnCyc + j * CPT, EV_BLINK, 0);
            end
        end
    endtask

    task automatic expectEvent(input int kind, input int val);
        event_t e;
        if (expQ.size() == 0) begin
            checkOutput("spurious event kind", kind, 0);
        end else begin
            e = expQ.pop_front();
            checkOutput("event kind", kind, e.kind);
            checkOutput("event cycle", edgeCount, e.cyc);
            checkOutput("event value", val, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prevBlink = blink;
        end else begin
            if (warn_start) expectEvent(EV_WARN, 1);
            if (fire_update) expectEvent(EV_FIRE, 1);
            if (blink !== prevBlink) expectEvent(EV_BLINK, int'(blink));
            prevBlink = blink;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        int f1, f2, f3, f4, f5;
        int dummy;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd0);

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("reset phase", int'(phase), 0);
        checkOutput("reset period", int'(period), BASE);
        checkOutput("reset warn_start", int'(warn_start), 0);
        checkOutput("reset fire_update", int'(fire_update), 0);
        checkOutput("reset warning", int'(warning), 0);
        checkOutput("reset blink", int'(blink), 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        checkOutput("idle phase", int'(phase), 0);
        checkOutput("idle queue", expQ.size(), 0);

        // Baseline: score 0, three uninterrupted updates
        applyStimulus(1'b1, 1'b0, 4'd0);
        r = edgeCount + 1;
        pushInterval(r, 8, 1'b1, f1);
        pushInterval(f1, 8, 1'b1, f2);
        pushInterval(f2, 8, 1'b1, f3);
        waitUntil(r);
        checkOutput("base phase active", int'(phase), 1);
        checkOutput("base period", int'(period), 8);
        waitUntil(r + 25);
        checkOutput("base phase warn", int'(phase), 2);
        checkOutput("base warning", int'(warning), 1);
        waitUntil(r + 33);
        checkOutput("base phase after fire", int'(phase), 1);
        checkOutput("base warning after fire", int'(warning), 0);
        waitUntil(f3 + 4);
        checkOutput("base queue drained", expQ.size(), 0);
        applyStimulus(1'b0, 1'b0, 4'd0);
        waitUntil(f3 + 5);
        checkOutput("base stop phase", int'(phase), 0);

        // Speed-up and clamp; score changes only land at the next sample
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 4'd3);
        r = edgeCount + 1;
        pushInterval(r, expPeriod(3), 1'b1, f1);
        pushInterval(f1, expPeriod(5), 1'b1, f2);
        pushInterval(f2, expPeriod(0), 1'b1, f3);
        pushInterval(f3, expPeriod(15), 1'b1, f4);
        pushInterval(f4, expPeriod(7), 1'b1, f5);
        waitUntil(r);
        checkOutput("speed period s3", int'(period), 5);
        waitUntil(r + 5);
        applyStimulus(1'b1, 1'b0, 4'd5);
        waitUntil(r + 10);
        checkOutput("speed period unchanged mid-interval", int'(period), 5);
        waitUntil(f1);
        checkOutput("speed period s5", int'(period), 3);
        waitUntil(f1 + 3);
        applyStimulus(1'b1, 1'b0, 4'd0);
        waitUntil(f2);
        checkOutput("speed period s0", int'(period), 8);
        waitUntil(f2 + 3);
        applyStimulus(1'b1, 1'b0, 4'd15);
        waitUntil(f3);
        checkOutput("speed period s15", int'(period), 3);
        waitUntil(f3 + 3);
        applyStimulus(1'b1, 1'b0, 4'd7);
        waitUntil(f4);
        checkOutput("speed period s7", int'(period), 3);
        waitUntil(f5 + 3);
        checkOutput("speed queue drained", expQ.size(), 0);
        applyStimulus(1'b0, 1'b0, 4'd0);
        waitUntil(f5 + 4);
        checkOutput("speed stop phase", int'(phase), 0);

        // Hold for 10 cycles mid-WARN, then abort at the next expiry
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 4'd0);
        r = edgeCount + 1;
        pushEvent(r + 24, EV_WARN, 1);
        pushEvent(r + 28, EV_BLINK, 1);
        pushEvent(r + 42, EV_FIRE, 1);
        pushEvent(r + 42, EV_BLINK, 0);
        pushInterval(r + 42, 8, 1'b0, dummy);
        waitUntil(r + 29);
        applyStimulus(1'b1, 1'b1, 4'd0);
        waitUntil(r + 34);
        checkOutput("hold blink frozen", int'(blink), 1);
        checkOutput("hold warning", int'(warning), 1);
        checkOutput("hold phase", int'(phase), 2);
        waitUntil(r + 39);
        applyStimulus(1'b1, 1'b0, 4'd0);
        waitUntil(r + 42);
        checkOutput("hold delayed fire", int'(fire_update), 1);
        waitUntil(r + 73);
        applyStimulus(1'b0, 1'b0, 4'd0);
        waitUntil(r + 74);
        checkOutput("abort fire_update", int'(fire_update), 0);
        checkOutput("abort phase", int'(phase), 0);
        checkOutput("abort warning", int'(warning), 0);
        waitUntil(r + 80);
        checkOutput("abort queue drained", expQ.size(), 0);

        // Asynchronous reset mid-WARN, then a fresh baseline schedule
        applyStimulus(1'b1, 1'b0, 4'd3);
        r = edgeCount + 1;
        pushEvent(r + 12, EV_WARN, 1);
        pushEvent(r + 16, EV_BLINK, 1);
        waitUntil(r + 17);
        checkOutput("pre-reset phase", int'(phase), 2);
        checkOutput("pre-reset queue", expQ.size(), 0);
        #1 rst = 1'b1;
        #1;
        checkOutput("async phase", int'(phase), 0);
        checkOutput("async period", int'(period), BASE);
        checkOutput("async warning", int'(warning), 0);
        checkOutput("async blink", int'(blink), 0);
        checkOutput("async fire_update", int'(fire_update), 0);
        checkOutput("async warn_start", int'(warn_start), 0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 4'd0);
        r = edgeCount + 1;
        pushInterval(r, 8, 1'b1, f1);
        pushInterval(f1, 8, 1'b1, f2);
        waitUntil(r);
        checkOutput("rebase phase", int'(phase), 1);
        checkOutput("rebase period", int'(period), 8);
        waitUntil(f2 + 4);
        checkOutput("rebase queue drained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
